// File: rtl/muldiv_pkg.sv
// Shared constants, op encoding and FSM states for the iterative mul/div unit.
// Divide hardware is included only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 6;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_MULU = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_DIVU = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_e;

   function automatic logic [XLEN-1:0] mag(
      input logic [XLEN-1:0] v,
      input logic            neg
   );
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide (divide path present only with MULDIV_DIV_EN).
module muldiv_step
   import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
   input  logic            div_i,
`endif
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] sum;

   assign sum = {1'b0, hi_i}
              + (lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});

`ifdef MULDIV_DIV_EN
   logic [XLEN:0]   sh;
   logic [XLEN-1:0] rem;
   logic            ge;

   // The partial remainder never exceeds the divisor, so 32-bit wrap is exact.
   assign sh  = {hi_i, lo_i[XLEN-1]};
   assign ge  = (sh >= {1'b0, opnd_i});
   assign rem = sh[XLEN-1:0] - opnd_i;

   always_comb begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
      if (div_i) begin
         hi_o = ge ? rem : sh[XLEN-1:0];
         lo_o = {lo_i[XLEN-2:0], ge};
      end
   end
`else
   assign hi_o = sum[XLEN:1];
   assign lo_o = {sum[0], lo_i[XLEN-1:1]};
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Fixed-latency iterative multiply/divide unit (34 cycles start to done).
// Define MULDIV_DIV_EN to include the divide datapath.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [1:0]      op,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            div_zero
);

   state_e state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic [XLEN-1:0]  opnd_q, opnd_d;
   logic [XLEN-1:0]  acc_hi_q, acc_hi_d;
   logic [XLEN-1:0]  acc_lo_q, acc_lo_d;
   logic [XLEN-1:0]  hi_q, hi_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
`ifdef MULDIV_DIV_EN
   logic             bz_q, bz_d;
`endif

   logic             accept;
   logic             step_en;
   logic             fix_en;
   logic             load_en;
   logic             in_div;
   logic             in_sgn;
   logic             a_neg;
   logic             b_neg;
   logic             div_q;
   logic [XLEN-1:0]  st_hi;
   logic [XLEN-1:0]  st_lo;
   logic [2*XLEN-1:0] prod;

   assign in_div = (op == OP_DIV) || (op == OP_DIVU);
   assign in_sgn = (op == OP_MUL) || (op == OP_DIV);
   assign a_neg  = in_sgn & a[XLEN-1];
   assign b_neg  = in_sgn & b[XLEN-1];
   assign div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);
   assign prod   = {acc_hi_q, acc_lo_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = S_RUN;
         S_RUN:  if (cnt_q == LAST_STEP) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A start during the done pulse is dropped; it must come one cycle later.
   always_comb begin
      busy    = 1'b0;
      accept  = 1'b0;
      step_en = 1'b0;
      fix_en  = 1'b0;
      load_en = 1'b0;
      unique case (1'b1)
         (state_q == S_IDLE): accept = start & ~done_q;
         (state_q == S_RUN): begin
            busy    = 1'b1;
            step_en = 1'b1;
         end
         (state_q == S_FIX): begin
            busy   = 1'b1;
            fix_en = 1'b1;
         end
         (state_q == S_DONE): begin
            busy    = 1'b1;
            load_en = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   muldiv_step u_step (
`ifdef MULDIV_DIV_EN
      .div_i  (div_q),
`endif
      .hi_i   (acc_hi_q),
      .lo_i   (acc_lo_q),
      .opnd_i (opnd_q),
      .hi_o   (st_hi),
      .lo_o   (st_lo)
   );

   always_comb begin
      cnt_d    = cnt_q;
      op_d     = op_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      opnd_d   = opnd_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dz_d     = dz_q;
      done_d   = 1'b0;
`ifdef MULDIV_DIV_EN
      bz_d     = bz_q;
`endif
      unique case (1'b1)
         accept: begin
            cnt_d    = '0;
            op_d     = op;
            sa_d     = a_neg;
            sb_d     = b_neg;
            acc_hi_d = '0;
            opnd_d   = in_div ? mag(b, b_neg) : mag(a, a_neg);
            acc_lo_d = in_div ? mag(a, a_neg) : mag(b, b_neg);
`ifdef MULDIV_DIV_EN
            bz_d     = (b == '0);
`endif
         end
         step_en: begin
            cnt_d    = cnt_q + CNT_W'(1);
            acc_hi_d = st_hi;
            acc_lo_d = st_lo;
         end
         fix_en: begin
            unique case (op_q)
               OP_MUL, OP_MULU: begin
                  {acc_hi_d, acc_lo_d} = (sa_q ^ sb_q) ? -prod : prod;
               end
               OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                  // Zero divisor leaves |a| as remainder; re-signing restores a.
                  acc_hi_d = mag(acc_hi_q, sa_q);
                  acc_lo_d = bz_q ? '1 : mag(acc_lo_q, sa_q ^ sb_q);
`else
                  acc_hi_d = '0;
                  acc_lo_d = '0;
`endif
               end
               default: acc_hi_d = acc_hi_q;
            endcase
         end
         load_en: begin
            hi_d   = acc_hi_q;
            lo_d   = acc_lo_q;
            done_d = 1'b1;
            if (div_q) begin
`ifdef MULDIV_DIV_EN
               dz_d = bz_q;
`else
               dz_d = 1'b0;
`endif
            end
         end
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         op_q     <= OP_MUL;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         opnd_q   <= opnd_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

`ifdef MULDIV_DIV_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bz_q <= 1'b0;
      end else begin
         bz_q <= bz_d;
      end
   end
`endif

   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, abort by reset,
// stray starts and randomized ops against a plain-arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [1:0]  op = '0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_zero;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;
   logic        exp_dz = 1'b0;

   muldiv_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .op       (op),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
      longint      sx;
      longint      sy;
      longint      p;
      logic [63:0] pu;
`ifdef MULDIV_DIV_EN
      longint      q;
      longint      r;
`endif
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00: begin
            p = sx * sy;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
         end
         2'b01: begin
            pu = {32'b0, x} * {32'b0, y};
            exp_hi = pu[63:32];
            exp_lo = pu[31:0];
         end
         default: begin
`ifdef MULDIV_DIV_EN
            if (y == 0) begin
               exp_hi = x;
               exp_lo = '1;
               exp_dz = 1'b1;
            end else begin
               exp_dz = 1'b0;
               if (o == 2'b10) begin
                  q = sx / sy;
                  r = sx % sy;
                  exp_lo = q[31:0];
                  exp_hi = r[31:0];
               end else begin
                  exp_lo = x / y;
                  exp_hi = x % y;
               end
            end
`else
            exp_hi = '0;
            exp_lo = '0;
            exp_dz = 1'b0;
`endif
         end
      endcase
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input string tag,
                         input int stray_k);
      int   kdone;
      logic busy1;
      kdone = -1;
      busy1 = 1'b0;
      @(negedge clk);
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      op = 2'($urandom);
      model(o, x, y);
      for (int k = 1; k <= 40 && kdone < 0; k++) begin
         @(negedge clk);
         start = (k == stray_k);
         if (k == stray_k) begin
            a = $urandom;
            b = $urandom;
            op = 2'($urandom);
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (k == 1) busy1 = busy;
         if (done) kdone = k;
      end
      chk({tag, " latency"}, kdone, 34);
      chk({tag, " busy"}, busy1, 1'b1);
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " lo"}, lo, exp_lo);
      chk({tag, " div_zero"}, div_zero, exp_dz);
      @(posedge clk);
      #1;
      chk({tag, " done clear"}, done, 1'b0);
      chk({tag, " hold hi"}, hi, exp_hi);
      chk({tag, " hold lo"}, lo, exp_lo);
   endtask

   task automatic run_abort(input int abort_k);
      logic saw;
      saw = 1'b0;
      @(negedge clk);
      op = 2'b01;
      a = 32'd1234;
      b = 32'd5678;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (abort_k) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort hi", hi, 32'h0);
      chk("abort lo", lo, 32'h0);
      chk("abort busy", busy, 1'b0);
      chk("abort done", done, 1'b0);
      chk("abort div_zero", div_zero, 1'b0);
      exp_hi = '0;
      exp_lo = '0;
      exp_dz = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) saw = 1'b1;
      end
      chk("abort no done", saw, 1'b0);
   endtask

   initial begin
      logic [31:0] pool [6];
      logic [31:0] rx;
      logic [31:0] ry;
      logic [1:0]  ro;
      pool[0] = 32'h0000_0000;
      pool[1] = 32'hFFFF_FFFF;
      pool[2] = 32'h8000_0000;
      pool[3] = 32'h7FFF_FFFF;
      pool[4] = 32'h0000_0001;
      pool[5] = 32'h0000_0003;

      #1;
      chk("reset hi", hi, 32'h0);
      chk("reset lo", lo, 32'h0);
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset div_zero", div_zero, 1'b0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max", 0);
      run_op(2'b00, -32'sd3, 32'd5, "mult -3x5", 0);
      run_op(2'b10, -32'sd7, 32'd2, "div -7/2", 0);
      run_op(2'b11, 32'h64, 32'h0, "divu 100/0", 0);
      run_op(2'b11, 32'h64, 32'h3, "divu 100/3", 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", 0);
      run_op(2'b10, -32'sd9, 32'h0, "div neg/0", 0);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult minsq", 0);
      run_op(2'b00, 32'd12345, -32'sd678, "mult stray", 5);
      run_op(2'b01, 32'd6, 32'd7, "pre-abort", 0);
      run_abort(10);
      run_op(2'b00, 32'd6, 32'd7, "mult 6x7", 0);

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom);
         rx = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)]
                                          : $urandom;
         ry = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)]
                                          : $urandom;
         if ($urandom_range(0, 2) == 0) ry = ry >> $urandom_range(8, 31);
         run_op(ro, rx, ry, $sformatf("rand%0d op%0d", i, ro), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; data width SHALL be fixed at 32 through the shared package constant.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 a  input  32  multiplicand or dividend, sampled with start.
REQ-005 b  input  32  multiplier or divisor, sampled with start.
REQ-006 op  input  2  operation: 00 mult signed, 01 multu, 10 div signed, 11 divu; sampled with start.
REQ-007 start  input  1  request; accepted only in IDLE.
REQ-008 busy  output  1  high from the cycle after acceptance until done.
REQ-009 done  output  1  one-cycle pulse; hi/lo/div_zero valid in that cycle.
REQ-010 hi  output  32  mult: product[63:32]; div: remainder.
REQ-011 lo  output  32  mult: product[31:0]; div: quotient.
REQ-012 div_zero  output  1  divisor was zero on the last completed divide.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, FIX and DONE.
REQ-014 IDLE with start=1 SHALL latch a, b and op, clear the iteration counter, and go to RUN.
REQ-015 RUN SHALL perform one radix-2 step per cycle for exactly 32 cycles, then go to FIX.
- mult step: shift-add on operand magnitudes.
- div step: restoring shift-subtract on operand magnitudes.
REQ-016 FIX SHALL apply sign correction for signed ops, then go to DONE.
- Signed mult: negate the 64-bit product when the operand signs differ.
- Signed div: quotient truncated toward zero; remainder takes the dividend's sign.
REQ-017 DONE SHALL load hi, lo and div_zero, pulse done, and return to IDLE.
REQ-018 Latency SHALL be fixed for every op: done high exactly 34 cycles after the start-sampling edge.
REQ-019 Back-to-back: start may be accepted in the cycle after done.
REQ-020 start while busy=1 or done=1 SHALL be ignored, with no effect on the operation in flight.
REQ-021 Divide by zero SHALL keep full latency and give hi=a, lo=32'hFFFFFFFF, div_zero=1.
REQ-022 Any non-zero divisor divide SHALL clear div_zero.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-024 hi, lo and div_zero SHALL hold their values between done pulses.
REQ-025 Input changes after acceptance SHALL have no effect on the result.

Reset
REQ-026 rst_n low SHALL immediately force hi=0, lo=0, busy=0, done=0, div_zero=0, state IDLE and counter 0.
REQ-027 Reset during RUN or FIX SHALL abort the operation with no done pulse.
REQ-028 The first start after reset release SHALL operate normally.

Configuration
REQ-029 Macro MULDIV_DIV_EN defined SHALL include divide hardware, with ops 10/11 as specified above.
REQ-030 Macro MULDIV_DIV_EN undefined SHALL omit divide logic; ops 10/11 then complete with the same latency, hi=0, lo=0, div_zero=0.

Structure
REQ-031 Package muldiv_pkg SHALL hold:
- width constant (32) and counter width (6);
- op encoding constants;
- the FSM state enum.
REQ-032 Sub-module muldiv_step SHALL implement one combinational iteration (add/subtract plus shift) for both modes.
REQ-033 muldiv_unit SHALL hold the FSM, counter and registers.

Verification
REQ-034 multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at cycle 34.
REQ-035 mult -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-036 div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-037 divu 0x64 / 0 -> hi=0x64, lo=0xFFFFFFFF, div_zero=1; then divu 0x64 / 3 -> lo=0x21, hi=1, div_zero=0.
REQ-038 Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 Reset and stray-start checks:
- start pulsed at RUN cycle 5 -> ignored, result unchanged;
- rst_n low at RUN cycle 10 -> all outputs 0, no done;
- next start 6 x 7 -> lo=0x2A.
